solve_monitor: RTL and testbench



---
 rtl/solve_monitor.sv | 183 ++++++++++++++++++
 tb/tb_solve_monitor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/solve_monitor.sv
`default_nettype none
// ============================================================================
// Module   : solve_monitor
// Purpose  : Watches the solver grid after a start pulse, decides solved /
//            fail / stalled, freezes the grid and streams it out cell by cell.
// Revision : 1.0 - initial release
// ============================================================================
module solve_monitor #(
    parameter int WIDTH         = 9,
    parameter int N             = 3,
    parameter int DIGIT_W       = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_CYCLES    = 1024
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [WIDTH*WIDTH*WIDTH-1:0]   final_vals,
    input  logic                           fail_in,
    output logic [DIGIT_W-1:0]             out_digit,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic [1:0]                     status,
    output logic                           busy,
    output logic                           done
);

    localparam int c_cells    = WIDTH * WIDTH;
    localparam int c_grid_w   = c_cells * WIDTH;
    localparam int c_idx_w    = $clog2(c_cells);
    localparam int c_cnt_w    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int c_stable_w = $clog2(STABLE_CYCLES);

    localparam logic [c_idx_w-1:0]    c_last_idx   = c_idx_w'(c_cells - 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_max    = c_cnt_w'(MAX_CYCLES - 1);
    localparam logic [c_stable_w-1:0] c_stable_max = c_stable_w'(STABLE_CYCLES - 1);
    localparam logic [c_stable_w-1:0] c_stable_hit = c_stable_w'(STABLE_CYCLES - 2);

    localparam logic [1:0] c_st_none   = 2'd0;
    localparam logic [1:0] c_st_solved = 2'd1;
    localparam logic [1:0] c_st_fail   = 2'd2;
    localparam logic [1:0] c_st_stall  = 2'd3;

    if (N * N != WIDTH) begin : g_check_n
        $error("solve_monitor: WIDTH must equal N*N");
    end
    if ((2 ** DIGIT_W) <= WIDTH) begin : g_check_digit_w
        $error("solve_monitor: DIGIT_W too narrow for WIDTH");
    end
    if (STABLE_CYCLES < 2) begin : g_check_stable
        $error("solve_monitor: STABLE_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  state_q,      state_d;
    logic [c_cnt_w-1:0]      cycle_cnt_q,  cycle_cnt_d;
    logic [c_stable_w-1:0]   stable_cnt_q, stable_cnt_d;
    logic [c_grid_w-1:0]     prev_grid_q,  prev_grid_d;
    logic [c_grid_w-1:0]     snapshot_q,   snapshot_d;
    logic [c_idx_w-1:0]      cell_idx_q,   cell_idx_d;
    logic [1:0]              status_q,     status_d;

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    // Zero and multi-hot cells both read as "undetermined".
    function automatic logic [DIGIT_W-1:0] encode(input logic [WIDTH-1:0] v);
        logic [DIGIT_W-1:0] d;
        d = '0;
        if (is_onehot(v)) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (v[k]) d = DIGIT_W'(k + 1);
            end
        end
        return d;
    endfunction

    logic [c_cells-1:0] w_cell_ok;
    logic [DIGIT_W-1:0] w_enc [c_cells];

    for (genvar c = 0; c < c_cells; c++) begin : g_cell
        assign w_cell_ok[c] = is_onehot(final_vals[c*WIDTH +: WIDTH]);
        assign w_enc[c]     = encode(snapshot_q[c*WIDTH +: WIDTH]);
    end

    logic       w_same;
    logic       w_all_ok;
    logic       w_stall;
    logic       w_timeout;
    logic       w_exit;
    logic [1:0] w_exit_status;

    assign w_same    = (final_vals == prev_grid_q);
    assign w_all_ok  = &w_cell_ok;
    assign w_stall   = w_same && (stable_cnt_q == c_stable_hit);
    assign w_timeout = (cycle_cnt_q == c_cnt_max);
    assign w_exit    = fail_in || w_all_ok || w_stall || w_timeout;

    always_comb begin
        w_exit_status = c_st_stall;
        if (fail_in)       w_exit_status = c_st_fail;
        else if (w_all_ok) w_exit_status = c_st_solved;
    end

    always_comb begin
        state_d      = state_q;
        cycle_cnt_d  = cycle_cnt_q;
        stable_cnt_d = stable_cnt_q;
        prev_grid_d  = prev_grid_q;
        snapshot_d   = snapshot_q;
        cell_idx_d   = cell_idx_q;
        status_d     = status_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    cycle_cnt_d  = '0;
                    stable_cnt_d = '0;
                    prev_grid_d  = '0;
                    status_d     = c_st_none;
                end
            end
            S_RUN: begin
                if (!w_same)                          stable_cnt_d = '0;
                else if (stable_cnt_q != c_stable_max) stable_cnt_d = stable_cnt_q + 1'b1;
                prev_grid_d = final_vals;
                // Saturate so the final budget cycle cannot wrap the counter.
                if (!w_timeout) cycle_cnt_d = cycle_cnt_q + 1'b1;
                if (w_exit) begin
                    state_d    = S_STREAM;
                    status_d   = w_exit_status;
                    snapshot_d = final_vals;
                    cell_idx_d = '0;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (cell_idx_q == c_last_idx) state_d    = S_DONE;
                    else                          cell_idx_d = cell_idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cycle_cnt_q  <= '0;
            stable_cnt_q <= '0;
            prev_grid_q  <= '0;
            snapshot_q   <= '0;
            cell_idx_q   <= '0;
            status_q     <= c_st_none;
        end else begin
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            prev_grid_q  <= prev_grid_d;
            snapshot_q   <= snapshot_d;
            cell_idx_q   <= cell_idx_d;
            status_q     <= status_d;
        end
    end

    // Outputs derive from registered state only, so out_ready never reaches out_valid.
    assign out_valid = (state_q == S_STREAM);
    assign out_last  = out_valid && (cell_idx_q == c_last_idx);
    assign out_digit = out_valid ? w_enc[cell_idx_q] : '0;
    assign status    = status_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_STREAM);
    assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_solve_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_solve_monitor
// Purpose  : Directed scoreboard bench for solve_monitor (4x4 grid).
// Revision : 1.0 - initial release
// ============================================================================
module tb_solve_monitor;

    logic        clock = 1'b0;
    logic        reset, start, fail_in, out_ready;
    logic [63:0] final_vals;
    logic [2:0]  out_digit;
    logic        out_valid, out_last, busy, done;
    logic [1:0]  status;

    always #5 clock = ~clock;

    solve_monitor #(
        .WIDTH(4), .N(2), .DIGIT_W(3), .STABLE_CYCLES(4), .MAX_CYCLES(64)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .final_vals(final_vals),
        .fail_in(fail_in), .out_digit(out_digit), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .status(status),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [2:0] digit;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Grids: cell (r,c) occupies nibble r*4+c, cell 0 in the low nibble.
    // Digit tables: one nibble per cell in reading order, cell 0 leftmost.
    localparam logic [63:0] G_SOLVED = 64'h1248_4812_2184_8421;
    localparam logic [63:0] D_SOLVED = 64'h1234_3412_2143_4321;
    localparam logic [63:0] G_FAIL   = 64'h8421_2184_4812_1248;
    localparam logic [63:0] D_FAIL   = 64'h4321_2143_3412_1234;
    localparam logic [63:0] G_STALL  = 64'h0000_0000_0030_0004;
    localparam logic [63:0] D_STALL  = 64'h3000_0000_0000_0000;
    localparam logic [63:0] G_TO_A   = 64'h0000_0000_0000_0001;
    localparam logic [63:0] G_TO_B   = 64'h0000_0000_0000_0002;
    localparam logic [63:0] D_TO     = 64'h2000_0000_0000_0000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_digits(input logic [63:0] d);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.digit = d[(15-i)*4 +: 3];
            e.last  = (i == 15);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check(name, done, 1);
    endtask

    // Monitor: pops on every accepted cell and checks hold-stability under backpressure.
    initial begin : monitor
        logic       hold_pend;
        logic [2:0] hold_digit;
        logic       hold_last;
        exp_t       e;
        int         cell_n;
        hold_pend = 1'b0;
        hold_digit = '0;
        hold_last = 1'b0;
        cell_n = 0;
        forever begin
            @(negedge clock);
            if (hold_pend && !reset) begin
                check("hold_valid", out_valid, 1);
                check("hold_digit", out_digit, hold_digit);
                check("hold_last", out_last, hold_last);
            end
            hold_pend = 1'b0;
            if (!reset && out_valid && !out_ready) begin
                hold_pend  = 1'b1;
                hold_digit = out_digit;
                hold_last  = out_last;
            end
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cell", {out_digit, out_last}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("cell%0d", cell_n % 16), {out_digit, out_last}, e);
                end
                cell_n++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n, run, acc, hold;
        logic tog;
        reset = 1'b1; start = 1'b0; fail_in = 1'b0; out_ready = 1'b0; final_vals = '0;
        tick(); tick();
        reset = 1'b0;
        check("reset_outputs", {out_valid, out_last, out_digit, status, busy, done}, 0);

        // Solved: grid appears on the second RUN cycle.
        out_ready = 1'b1;
        push_digits(D_SOLVED);
        do_start();
        check("solved_run", {busy, out_valid, status}, {1'b1, 1'b0, 2'd0});
        tick();
        final_vals = G_SOLVED;
        check("solved_pre", {out_valid, status}, 0);
        tick();
        check("solved_status", {busy, out_valid, status}, {1'b1, 1'b1, 2'd1});
        wait_done("solved_done", n);
        check("solved_len", n, 16);
        check("solved_end", {out_valid, out_last, busy, status}, {1'b0, 1'b0, 1'b0, 2'd1});
        check("solved_count", exp_q.size(), 0);

        // Fail together with a complete grid on RUN cycle 3; fail must win.
        final_vals = '0;
        push_digits(D_FAIL);
        do_start();
        check("fail_restart", {busy, done, status}, {1'b1, 1'b0, 2'd0});
        tick(); tick();
        check("fail_pre", {out_valid, status}, 0);
        final_vals = G_FAIL;
        fail_in = 1'b1;
        tick();
        fail_in = 1'b0;
        final_vals = G_SOLVED;
        check("fail_status", {out_valid, status}, {1'b1, 2'd2});
        wait_done("fail_done", n);
        check("fail_count", exp_q.size(), 0);
        check("fail_hold", status, 2);

        // Stall: constant partial grid with a multi-hot cell 5.
        final_vals = G_STALL;
        push_digits(D_STALL);
        do_start();
        tick(); tick(); tick();
        check("stall_pre", {out_valid, status}, 0);
        tick();
        check("stall_status", {out_valid, status}, {1'b1, 2'd3});
        wait_done("stall_done", n);
        check("stall_count", exp_q.size(), 0);

        // Timeout: grid changes every cycle and is never complete.
        push_digits(D_TO);
        tog = 1'b0;
        run = 0;
        do_start();
        for (int k = 0; k < 200; k++) begin
            if (out_valid) break;
            if (busy) run++;
            tog = ~tog;
            final_vals = tog ? G_TO_A : G_TO_B;
            tick();
        end
        check("timeout_run_cycles", run, 64);
        check("timeout_status", status, 3);
        wait_done("timeout_done", n);
        check("timeout_count", exp_q.size(), 0);

        // Backpressure with start pulses issued during STREAM.
        final_vals = '0;
        out_ready = 1'b1;
        push_digits(D_SOLVED);
        do_start();
        tick();
        final_vals = G_SOLVED;
        tick();
        acc = 0;
        hold = 0;
        for (int k = 0; k < 100; k++) begin
            if (done) break;
            if (acc == 7 && hold < 5) begin
                out_ready = 1'b0;
                hold++;
                start = (hold == 3);
            end else if (hold >= 5) begin
                out_ready = ~out_ready;
                start = (acc == 10);
            end else begin
                out_ready = 1'b1;
                start = 1'b0;
            end
            if (out_valid && out_ready) acc++;
            tick();
        end
        start = 1'b0;
        check("bp_accepted", acc, 16);
        check("bp_done", {done, status}, {1'b1, 2'd1});
        check("bp_count", exp_q.size(), 0);

        // Reset while streaming cell 5, then a clean full puzzle.
        final_vals = '0;
        out_ready = 1'b1;
        push_digits(D_SOLVED);
        do_start();
        tick();
        final_vals = G_SOLVED;
        tick();
        acc = 0;
        for (int k = 0; k < 50 && acc < 5; k++) begin
            if (out_valid && out_ready) acc++;
            tick();
        end
        check("rst_reached_cell5", acc, 5);
        reset = 1'b1;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check("rst_outputs", {out_valid, out_last, out_digit, status, busy, done}, 0);
        tick();
        check("rst_idle", {busy, done, out_valid}, 0);
        out_ready = 1'b1;
        push_digits(D_SOLVED);
        do_start();
        wait_done("rst_done", n);
        check("rst_status", status, 1);
        check("rst_count", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
